// File: rtl/crcu_rst_apb_regs_pkg.sv
// Shared types and constants for the CRCU reset-control APB register bank.
package crcu_rst_pkg;

    // Three-phase APB slave sequencer
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Register map
    localparam logic [7:0]  CTL_BASE   = 8'h00;
    localparam logic [7:0]  STATUS_OFS = 8'h40;
    localparam logic [7:0]  LOCK_OFS   = 8'h44;

    // Fixed identification half-word reported in STATUS[31:16]
    localparam logic [15:0] RST_ID     = 16'hC2C0;

    // Control word field positions consumed by the reset generators
    localparam int EN    = 0;
    localparam int ASYNC = 1;
    localparam int POL   = 2;

    // Only the low byte of each control word is implemented
    localparam int CTL_STORED_W = 8;

endpackage

// File: rtl/crcu_rst_apb_regs_if.sv
// APB bus bundle between the CRCU reset register bank and its bus master.
interface crcu_rst_apb_regs_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/crcu_rst_apb_regs.sv
// CRCU per-channel reset control register bank on APB (one wait state).
// Optional feature macro: CRCU_RST_LOCK_EN adds a sticky LOCK register at
// 0x44 that blocks CTL writes until the next CRCU_RST.
module crcu_rst_apb_regs
    import crcu_rst_pkg::*;
#(
    parameter int          N_RST_CH     = 4,
    parameter logic [31:0] RST_CTL_INIT = 32'h0000_0000
) (
    input  logic                      CRCU_CLK,
    input  logic                      CRCU_RST,
    crcu_rst_apb_regs_if.slave        apb,
    output logic [32*N_RST_CH-1:0]    rst_ctl_reg,
    output logic [N_RST_CH-1:0]       ctl_upd
);

    state_e      state_q;
    logic [7:0]  addr_q;
    logic        wr_q;
    logic [31:0] wdata_q;

    logic        in_done;
    logic [3:0]  idx;
    logic        misal, hit_ctl, hit_stat, hit_lock;
    logic        lock, lock_clr_err;
    logic        err, commit;
    logic [31:0] rd_data;
    logic [N_RST_CH-1:0][CTL_STORED_W-1:0] ctl_all;

    // Upper write-data bits have no storage behind them
    logic unused_wdata;
    assign unused_wdata = ^wdata_q[31:CTL_STORED_W];

    // Transfer sequencer; request fields are captured on entry to WAIT
    always_ff @(posedge CRCU_CLK) begin
        if (CRCU_RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (apb.PSEL && !apb.PENABLE) begin
                    state_q <= WAIT;
                    addr_q  <= apb.PADDR;
                    wr_q    <= apb.PWRITE;
                    wdata_q <= apb.PWDATA;
                end
                WAIT:    state_q <= (apb.PSEL && apb.PENABLE) ? DONE : IDLE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_done  = (state_q == DONE);
    assign idx      = addr_q[5:2];
    assign misal    = (addr_q[1:0] != 2'b00);
    assign hit_ctl  = (addr_q[7:6] == CTL_BASE[7:6]) && ({1'b0, idx} < 5'(N_RST_CH));
    assign hit_stat = (addr_q == STATUS_OFS);

`ifdef CRCU_RST_LOCK_EN
    logic lock_q;

    // Sticky lock: only a write of 1 changes it, only reset clears it
    always_ff @(posedge CRCU_CLK) begin
        if (CRCU_RST)
            lock_q <= 1'b0;
        else if (commit && hit_lock && wdata_q[0])
            lock_q <= 1'b1;
    end

    assign lock         = lock_q;
    assign hit_lock     = (addr_q == LOCK_OFS);
    assign lock_clr_err = wr_q && hit_lock && lock_q && !wdata_q[0];
`else
    assign lock         = 1'b0;
    assign hit_lock     = 1'b0;
    assign lock_clr_err = 1'b0;
`endif

    assign err = misal
               | !(hit_ctl | hit_stat | hit_lock)
               | (wr_q & hit_stat)
               | (wr_q & hit_ctl & lock)
               | lock_clr_err;

    assign commit = in_done && wr_q && !err;

    // Read data selection from the latched address
    always_comb begin
        rd_data = '0;
        if (hit_stat)
            rd_data = {RST_ID, 7'b0, lock, 3'b0, 5'(N_RST_CH)};
        if (hit_lock)
            rd_data = {31'b0, lock};
        for (int i = 0; i < N_RST_CH; i++)
            if (hit_ctl && (idx == 4'(i)))
                rd_data = {{(32-CTL_STORED_W){1'b0}}, ctl_all[i]};
    end

    assign apb.PREADY  = in_done;
    assign apb.PSLVERR = in_done && err;
    assign apb.PRDATA  = (in_done && !wr_q && !err) ? rd_data : 32'h0;

    for (genvar i = 0; i < N_RST_CH; i++) begin : g_ch
        logic [CTL_STORED_W-1:0] ctl_q;
        logic                    upd_q;
        logic                    sel;

        assign sel = commit && hit_ctl && (idx == 4'(i));

        // Channel control byte plus a change strobe one cycle after commit
        always_ff @(posedge CRCU_CLK) begin
            if (CRCU_RST) begin
                ctl_q <= RST_CTL_INIT[CTL_STORED_W-1:0];
                upd_q <= 1'b0;
            end else begin
                upd_q <= 1'b0;
                if (sel) begin
                    ctl_q <= wdata_q[CTL_STORED_W-1:0];
                    upd_q <= (wdata_q[CTL_STORED_W-1:0] != ctl_q);
                end
            end
        end

        assign ctl_all[i]            = ctl_q;
        assign rst_ctl_reg[32*i +: 32] = {{(32-CTL_STORED_W){1'b0}}, ctl_q};
        assign ctl_upd[i]            = upd_q;
    end

endmodule

// File: tb/tb_crcu_rst_apb_regs.sv
// Randomized self-checking bench for crcu_rst_apb_regs with a register-map
// reference model; honours CRCU_RST_LOCK_EN if defined.
module tb_crcu_rst_apb_regs;

    localparam int N = 4;
`ifdef CRCU_RST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crcu_rst_apb_regs_if apb();
    logic [32*N-1:0] rst_ctl_reg;
    logic [N-1:0]    ctl_upd;

    crcu_rst_apb_regs #(.N_RST_CH(N), .RST_CTL_INIT(32'h0)) dut (
        .CRCU_CLK   (clk),
        .CRCU_RST   (rst),
        .apb        (apb),
        .rst_ctl_reg(rst_ctl_reg),
        .ctl_upd    (ctl_upd)
    );

    // Reference model
    logic [7:0] m_ctl [N];
    bit         m_lock;
    logic [N-1:0] exp_upd;
    bit         exp_ready;
    bit         chk_en;
    int         n_pass, n_total;
    int         cyc, last_done;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [32*N-1:0] pack();
        logic [32*N-1:0] r;
        for (int i = 0; i < N; i++) r[32*i +: 32] = {24'h0, m_ctl[i]};
        return r;
    endfunction

    function automatic bit m_err(input logic [7:0] a, input bit w, input logic [31:0] d);
        if (a[1:0] != 2'b00) return 1'b1;
        if (a < 8'h40) begin
            if (int'(a) / 4 >= N) return 1'b1;
            return w && m_lock;
        end
        if (a == 8'h40) return w;
        if (a == 8'h44 && LOCK_EN) return w && m_lock && !d[0];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_rd(input logic [7:0] a);
        if (a < 8'h40) return {24'h0, m_ctl[int'(a) / 4]};
        if (a == 8'h40) return 32'hC2C0_0000 + (32'(m_lock) << 8) + 32'(N);
        return 32'(m_lock);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctl[i] = 8'h00;
        m_lock  = 1'b0;
        exp_upd = '0;
    endtask

    // Per-cycle comparison of the register outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("rst_ctl_reg", 128'(rst_ctl_reg), 128'(pack()));
            check("ctl_upd", 128'(ctl_upd), 128'(exp_upd));
            check("pready", 128'(apb.PREADY), 128'(exp_ready));
            if (!exp_ready) check("prdata_idle", 128'(apb.PRDATA), 128'(0));
            exp_upd = '0;
        end
    end

    // One full APB transfer; starts and ends 1 time unit after a rising edge
    task automatic xfer(input logic [7:0] a, input bit w, input logic [31:0] d,
                        output logic [31:0] rd, output bit er);
        bit e;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
        apb.PADDR = a; apb.PWRITE = w; apb.PWDATA = d;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(posedge clk); #1;
        exp_ready = 1'b1;
        @(negedge clk);
        er = apb.PSLVERR;
        rd = apb.PRDATA;
        last_done = cyc;
        e = m_err(a, w, d);
        check("pslverr", 128'(er), 128'(e));
        if (!w && !e) check("prdata", 128'(rd), 128'(m_rd(a)));
        @(posedge clk); #1;
        exp_ready = 1'b0;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        if (w && !e) begin
            if (a < 8'h40) begin
                if (m_ctl[int'(a) / 4] != d[7:0]) exp_upd[int'(a) / 4] = 1'b1;
                m_ctl[int'(a) / 4] = d[7:0];
            end else if (a == 8'h44 && d[0]) begin
                m_lock = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        exp_ready = 1'b0;
    endtask

    task automatic align_neg();
        @(negedge clk);
    endtask

    task automatic align_pos();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit er;
        int d1;
        logic [7:0] pool [10];
        logic [7:0] a;

        pool = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h3C, 8'h40, 8'h44, 8'h48, 8'h02};
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        chk_en = 1'b0; exp_ready = 1'b0;
        n_pass = 0; n_total = 0;
        model_reset();

        // Reset state
        align_neg();
        check("rst_pready", 128'(apb.PREADY), 128'(0));
        check("rst_pslverr", 128'(apb.PSLVERR), 128'(0));
        check("rst_prdata", 128'(apb.PRDATA), 128'(0));
        check("rst_ctl", 128'(rst_ctl_reg), 128'(0));
        check("rst_upd", 128'(ctl_upd), 128'(0));
        align_pos();
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic reads
        xfer(8'h00, 1'b0, 32'h0, rd, er);
        check("rd_ctl0_lit", 128'(rd), 128'(32'h0));
        xfer(8'h40, 1'b0, 32'h0, rd, er);
        check("rd_status_lit", 128'(rd), 128'(32'hC2C0_0004));

        // Write with upper bits ignored, then identical rewrite
        xfer(8'h04, 1'b1, 32'hFFFF_0007, rd, er);
        align_neg();
        check("ctl1_lit", 128'(rst_ctl_reg[63:32]), 128'(32'h0000_0007));
        check("upd_lit", 128'(ctl_upd), 128'(4'b0010));
        align_pos();
        align_neg();
        check("upd_one_cycle_lit", 128'(ctl_upd), 128'(4'b0000));
        align_pos();
        xfer(8'h04, 1'b1, 32'h0000_0007, rd, er);
        align_neg();
        check("rewrite_no_upd_lit", 128'(ctl_upd), 128'(4'b0000));
        align_pos();

        // Error cases
        xfer(8'h10, 1'b1, 32'hFF, rd, er);
        check("err_ch4_lit", 128'(er), 128'(1));
        xfer(8'h02, 1'b1, 32'hFF, rd, er);
        check("err_misal_lit", 128'(er), 128'(1));
        xfer(8'h40, 1'b1, 32'hFF, rd, er);
        check("err_status_wr_lit", 128'(er), 128'(1));
        xfer(8'h48, 1'b0, 32'h0, rd, er);
        check("err_unmapped_lit", 128'(er), 128'(1));

        // PENABLE without SETUP is ignored
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b1;
        apb.PADDR = 8'h00; apb.PWDATA = 32'h55;
        align_pos();
        align_pos();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        align_pos();

        // Reset in the wait cycle of a write drops it
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 8'h00; apb.PWDATA = 32'h5;
        align_pos();
        apb.PENABLE = 1'b1;
        rst = 1'b1;
        align_pos();
        rst = 1'b0;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        model_reset();
        align_neg();
        check("midrst_ctl0_lit", 128'(rst_ctl_reg[31:0]), 128'(32'h0));
        check("midrst_pready_lit", 128'(apb.PREADY), 128'(0));
        align_pos();
        xfer(8'h00, 1'b1, 32'h3, rd, er);
        check("post_rst_wr_lit", 128'(er), 128'(0));
        align_neg();
        check("post_rst_ctl0_lit", 128'(rst_ctl_reg[31:0]), 128'(32'h3));
        align_pos();

`ifdef CRCU_RST_LOCK_EN
        xfer(8'h44, 1'b1, 32'h1, rd, er);
        check("lock_set_lit", 128'(er), 128'(0));
        xfer(8'h00, 1'b1, 32'h1, rd, er);
        check("locked_wr_lit", 128'(er), 128'(1));
        xfer(8'h40, 1'b0, 32'h0, rd, er);
        check("status_lock_lit", 128'(rd), 128'(32'hC2C0_0104));
        xfer(8'h44, 1'b1, 32'h0, rd, er);
        check("lock_clr_lit", 128'(er), 128'(1));
        xfer(8'h00, 1'b0, 32'h0, rd, er);
        check("locked_rd_lit", 128'(rd), 128'(32'h3));
        do_reset();
        xfer(8'h00, 1'b1, 32'h1, rd, er);
        check("unlocked_wr_lit", 128'(er), 128'(0));
`endif

        // Back-to-back write then read
        xfer(8'h00, 1'b1, 32'h1, rd, er);
        d1 = last_done;
        xfer(8'h00, 1'b0, 32'h0, rd, er);
        check("b2b_rd_lit", 128'(rd), 128'(32'h1));
        check("b2b_spacing", 128'(last_done - d1), 128'(3));

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                              : pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 19) == 0) begin
                // Aborted transfer: SETUP followed by deselect
                apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
                apb.PADDR = a; apb.PWDATA = $urandom;
                align_pos();
                apb.PSEL = 1'b0;
                align_pos();
            end else if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                xfer(a, 1'($urandom_range(0, 1)), $urandom, rd, er);
            end
            if ($urandom_range(0, 7) == 0)
                repeat ($urandom_range(1, 3)) align_pos();
        end

        align_pos();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
